// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the writeback/register-file slice.
//   - icode values for the Y86-64 instruction set (HALT .. POPQ)
//   - register IDs with special meaning (RSP, NONE)
//   - processor status codes as an enum
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/writeback_rf_if.sv
// writeback_rf_if: pipeline-side bundle for writeback_rf.
//   master (pipeline / bench): drives icode, ifun, rA, rB, cnd, valE, valM,
//                              instr_valid, imem_error, dmem_error
//   slave  (writeback_rf)    : drives valA, valB, stat, halted
interface writeback_rf_if;
  import y86_pkg::*;

  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [63:0] valA;
  logic [63:0] valB;
  stat_t       stat;
  logic        halted;

  modport master (
    output icode, ifun, rA, rB, cnd, valE, valM,
           instr_valid, imem_error, dmem_error,
    input  valA, valB, stat, halted
  );

  modport slave (
    input  icode, ifun, rA, rB, cnd, valE, valM,
           instr_valid, imem_error, dmem_error,
    output valA, valB, stat, halted
  );

endinterface

// File: rtl/writeback_rf_regfile.sv
// regfile: 15 x 64-bit register file, IDs 0..14.
//   clk, rst_n      : clock, asynchronous active-low clear of every register
//   src_a_i/src_b_i : read IDs; ID 0xF reads as 0 (combinational)
//   rd_a_o/rd_b_o   : read data
//   dst_e_i/val_e_i : write port E (enable we_e_i)
//   dst_m_i/val_m_i : write port M (enable we_m_i); wins over E on same ID
// Writes addressed to 0xF match no register and are dropped.
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a_i,
  input  logic [3:0]  src_b_i,
  output logic [63:0] rd_a_o,
  output logic [63:0] rd_b_o,
  input  logic        we_e_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i
);

  logic [63:0] regs [15];

  for (genvar gi = 0; gi < 15; gi++) begin : gen_reg
    logic [63:0] reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else if (we_m_i && dst_m_i == 4'(gi)) begin
        // M checked first so popq %rsp keeps the popped value
        reg_q <= val_m_i;
      end else if (we_e_i && dst_e_i == 4'(gi)) begin
        reg_q <= val_e_i;
      end
    end

    assign regs[gi] = reg_q;
  end

  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a_i == 4'(i)) rd_a_o = regs[i];
      if (src_b_i == 4'(i)) rd_b_o = regs[i];
    end
  end

endmodule

// File: rtl/writeback_rf.sv
// writeback_rf: Y86-64 decode/writeback stage with register file and status.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb (slave) : instruction fields, execute/memory results and fault flags in;
//                decode read data valA/valB, stat and halted out
//   retired    : (only with WB_RETIRE_CNT_EN defined) 64-bit count of
//                instructions retired while the processor stays AOK
// Optional feature macro: WB_RETIRE_CNT_EN.
module writeback_rf
  import y86_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  writeback_rf_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]    retired
`endif
);

  logic [3:0] src_a, src_b, dst_e, dst_m;
  stat_t      stat_q, stat_d;
  logic       wr_en;

  // ifun does not affect writeback; cmov condition already arrives as cnd
  logic unused_ifun;
  assign unused_ifun = ^wb.ifun;

  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (wb.icode)
      IRRMOVQ: begin
        src_a = wb.rA;
        if (wb.cnd) dst_e = wb.rB;
      end
      IIRMOVQ: dst_e = wb.rB;
      IRMMOVQ: begin
        src_a = wb.rA;
        src_b = wb.rB;
      end
      IMRMOVQ: begin
        src_b = wb.rB;
        dst_m = wb.rA;
      end
      IOPQ: begin
        src_a = wb.rA;
        src_b = wb.rB;
        dst_e = wb.rB;
      end
      ICALL: begin
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      IRET: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      IPUSHQ: begin
        src_a = wb.rA;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      IPOPQ: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
        dst_m = wb.rA;
      end
      default: ;
    endcase
  end

  // Status FSM: once out of AOK it stays put until reset.
  always_comb begin
    stat_d = stat_q;
    if (stat_q == STAT_AOK) begin
      if (wb.imem_error)       stat_d = STAT_ADR;
      else if (!wb.instr_valid) stat_d = STAT_INS;
      else if (wb.dmem_error)  stat_d = STAT_ADR;
      else if (wb.icode == IHALT) stat_d = STAT_HLT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= STAT_AOK;
    else        stat_q <= stat_d;
  end

  // The faulting instruction itself must not write, hence the look at stat_d.
  assign wr_en = (stat_q == STAT_AOK) && (stat_d == STAT_AOK);

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .rd_a_o  (wb.valA),
    .rd_b_o  (wb.valB),
    .we_e_i  (wr_en),
    .dst_e_i (dst_e),
    .val_e_i (wb.valE),
    .we_m_i  (wr_en),
    .dst_m_i (dst_m),
    .val_m_i (wb.valM)
  );

  assign wb.stat   = stat_q;
  assign wb.halted = (stat_q != STAT_AOK);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (wr_en) retired_d = retired_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_writeback_rf.sv
// tb_writeback_rf: randomized + directed bench for writeback_rf with a
// scoreboard. The driver computes the expected combinational outputs from a
// behavioural model and queues them; a monitor pops and compares on negedge.
module tb_writeback_rf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  writeback_rf_if wb ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
  writeback_rf dut (.clk(clk), .rst_n(rst_n), .wb(wb), .retired(retired));
`else
  writeback_rf dut (.clk(clk), .rst_n(rst_n), .wb(wb));
`endif

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] st;
    logic        hlt;
    logic [63:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // ---------------- reference model ----------------
  logic [63:0] m_regs [16];
  int          m_stat;     // 1 AOK, 2 HLT, 3 ADR, 4 INS
  logic [63:0] m_ret;

  function automatic int f_srcA(int ic, int ra);
    if (ic inside {2, 4, 6, 10}) return ra;
    if (ic inside {9, 11})       return 4;
    return 15;
  endfunction

  function automatic int f_srcB(int ic, int rb);
    if (ic inside {4, 5, 6})      return rb;
    if (ic inside {8, 9, 10, 11}) return 4;
    return 15;
  endfunction

  function automatic int f_dstE(int ic, int rb, bit c);
    if ((ic == 2 && c) || ic == 3 || ic == 6) return rb;
    if (ic inside {8, 9, 10, 11})             return 4;
    return 15;
  endfunction

  function automatic int f_dstM(int ic, int ra);
    if (ic == 5 || ic == 11) return ra;
    return 15;
  endfunction

  function automatic logic [63:0] f_read(int id);
    if (id == 15) return 64'd0;
    return m_regs[id];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_stat = 1;
    m_ret  = 64'd0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: icode=%0d rA=%0d rB=%0d valA=%0h valB=%0h stat=%0d halted=%0b",
                 txn, wb.icode, wb.rA, wb.rB, wb.valA, wb.valB, wb.stat, wb.halted);
        chk("valA", wb.valA, e.a);
        chk("valB", wb.valB, e.b);
        chk("stat", 64'(wb.stat), e.st);
        chk("halted", {63'd0, wb.halted}, {63'd0, e.hlt});
`ifdef WB_RETIRE_CNT_EN
        chk("retired", retired, e.ret);
`endif
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; applies one instruction for one cycle.
  task automatic drive(input int ic, input int ra, input int rb, input bit c,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input bit iv, input bit ie, input bit de);
    exp_t e;
    int   nxt;
    wb.icode = 4'(ic); wb.ifun = 4'($urandom_range(0, 15));
    wb.rA = 4'(ra); wb.rB = 4'(rb); wb.cnd = c;
    wb.valE = ve; wb.valM = vm;
    wb.instr_valid = iv; wb.imem_error = ie; wb.dmem_error = de;

    e.a   = f_read(f_srcA(ic, ra));
    e.b   = f_read(f_srcB(ic, rb));
    e.st  = 64'(m_stat);
    e.hlt = (m_stat != 1);
    e.ret = m_ret;
    exp_q.push_back(e);

    if (m_stat == 1) begin
      if (ie)        nxt = 3;
      else if (!iv)  nxt = 4;
      else if (de)   nxt = 3;
      else if (ic == 0) nxt = 2;
      else           nxt = 1;
      if (nxt == 1) begin
        m_ret = m_ret + 64'd1;
        if (f_dstE(ic, rb, c) != 15) m_regs[f_dstE(ic, rb, c)] = ve;
        if (f_dstM(ic, ra) != 15)    m_regs[f_dstM(ic, ra)]    = vm;
      end
      m_stat = nxt;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic op(input int ic, input int ra, input int rb, input bit c,
                    input logic [63:0] ve, input logic [63:0] vm);
    drive(ic, ra, rb, c, ve, vm, 1'b1, 1'b0, 1'b0);
  endtask

  // Assert reset between edges, check regs 2/4 read 0 at once, release.
  task automatic reset_mid();
    exp_t e;
    rst_n = 1'b0;
    wb.icode = 4'd6; wb.rA = 4'd2; wb.rB = 4'd4; wb.cnd = 1'b0;
    wb.instr_valid = 1'b1; wb.imem_error = 1'b0; wb.dmem_error = 1'b0;
    m_reset();
    e.a = 64'd0; e.b = 64'd0; e.st = 64'd1; e.hlt = 1'b0; e.ret = 64'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int r, ic;
    rst_n = 1'b0;
    wb.icode = 4'd1; wb.ifun = 4'd0; wb.rA = 4'hF; wb.rB = 4'hF; wb.cnd = 1'b0;
    wb.valE = 64'd0; wb.valM = 64'd0;
    wb.instr_valid = 1'b1; wb.imem_error = 1'b0; wb.dmem_error = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_mid();

    // irmovq then read back through opq
    op(3, 15, 2, 0, 64'd15, 64'd0);
    op(6, 2, 15, 0, 64'd0, 64'd0);
    // cmov not taken, taken, then read register 3
    op(2, 1, 3, 0, 64'd7, 64'd0);
    op(6, 3, 3, 0, 64'd0, 64'd0);
    op(2, 1, 3, 1, 64'd7, 64'd0);
    op(6, 3, 15, 0, 64'd0, 64'd0);
    // popq %rsp: valM wins
    op(11, 4, 15, 0, 64'd2047, 64'd99);
    op(8, 15, 15, 0, 64'd99, 64'd0);
    // stack sequence
    op(10, 2, 15, 0, 64'd2039, 64'd0);
    op(8, 15, 15, 0, 64'd2031, 64'd0);
    op(9, 15, 15, 0, 64'd2039, 64'd500);
    op(9, 15, 15, 0, 64'd2039, 64'd0);
    op(1, 15, 15, 0, 64'd0, 64'd0);
    // nop / jXX with real-looking fields must not write
    op(1, 2, 4, 1, 64'd1234, 64'd5678);
    op(7, 2, 4, 1, 64'd1234, 64'd5678);
    op(6, 2, 4, 0, 64'd0, 64'd0);
    // reset mid-run after regs 2 and 4 hold data
    reset_mid();
    // data fault on mrmovq, then writes ignored
    drive(5, 1, 15, 0, 64'd0, 64'd5, 1'b1, 1'b0, 1'b1);
    op(3, 15, 1, 0, 64'd77, 64'd0);
    op(6, 1, 1, 0, 64'd0, 64'd0);
    reset_mid();
    drive(3, 15, 1, 0, 64'd9, 64'd0, 1'b0, 1'b0, 1'b0);
    op(6, 1, 1, 0, 64'd0, 64'd0);
    reset_mid();
    op(0, 15, 15, 0, 64'd0, 64'd0);
    op(3, 15, 1, 0, 64'd3, 64'd0);
    op(6, 1, 1, 0, 64'd0, 64'd0);
    // imem fault has top priority
    reset_mid();
    drive(0, 15, 15, 0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    op(6, 1, 1, 0, 64'd0, 64'd0);
    reset_mid();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 99);
      ic = (r < 3) ? 0 : $urandom_range(1, 11);
      drive(ic, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 49) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 49) == 0);
      if (m_stat != 1 && $urandom_range(0, 2) == 0) reset_mid();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_rf.md
WRITEBACK_RF -- requirements
Module: writeback_rf

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the ports icode and ifun, input, 4 bits each: instruction code and function of the current instruction.
REQ-004 The block SHALL have the ports rA and rB, input, 4 bits each: register specifiers; 0xF means none.
REQ-005 The block SHALL have the port cnd, input, 1 bit: condition result from execute.
REQ-006 The block SHALL have the ports valE and valM, input, 64 bits each: ALU result and memory read data.
REQ-007 The block SHALL have the ports instr_valid, imem_error and dmem_error, input, 1 bit each: fetch-valid, fetch-fault and memory-fault flags.
REQ-008 The block SHALL have the ports valA and valB, output, 64 bits each: combinational decode read data.
REQ-009 The block SHALL have the port stat, output, 3 bits: processor status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-010 The block SHALL have the port halted, output, 1 bit: high whenever stat != AOK.

Function
REQ-011 The block SHALL hold 15 registers of 64 bits, IDs 0..14, with RSP = 4.
REQ-012 srcA SHALL be:
- rA for icode 2, 4, 6, 10;
- RSP for icode 9, 11;
- otherwise 0xF.
REQ-013 srcB SHALL be:
- rB for icode 4, 5, 6;
- RSP for icode 8, 9, 10, 11;
- otherwise 0xF.
REQ-014 valA and valB SHALL be combinational reads of the current register contents for srcA and srcB, returning 0 when the ID is 0xF.
REQ-015 dstE SHALL be:
- rB for icode 2 when cnd = 1;
- rB for icode 3 and 6;
- RSP for icode 8, 9, 10, 11;
- otherwise 0xF.
REQ-016 dstM SHALL be rA for icode 5 and 11, otherwise 0xF.
REQ-017 On the rising clk edge, valE SHALL be written to dstE and valM to dstM, subject to REQ-021.
- A write to ID 0xF SHALL be discarded.
REQ-018 When dstE equals dstM, valM SHALL win, so that popq %rsp leaves RSP equal to the popped value.
REQ-019 A write SHALL be visible on valA and valB in the cycle after the edge; there is no same-cycle bypass.
REQ-020 The stat state machine SHALL evaluate the following in priority order while in AOK, and move on the clock edge:
- imem_error: go to ADR.
- else instr_valid = 0: go to INS.
- else dmem_error: go to ADR.
- else icode = 0: go to HLT.
- else stay in AOK.
REQ-021 HLT, ADR and INS SHALL be terminal until reset.
- Register writes SHALL be suppressed in the cycle that causes the exit from AOK and in every cycle after it.
REQ-022 icode values 1 (nop) and 7 (jXX) SHALL perform no register write.

Reset
REQ-023 While rst_n = 0, all 15 registers SHALL be cleared to 0 asynchronously and stat SHALL be AOK, so halted = 0.
REQ-024 Reset asserted mid-operation SHALL abort any pending write.
- The first write SHALL occur on the first rising edge with rst_n = 1.

Configuration
REQ-025 With the macro WB_RETIRE_CNT_EN defined, the block SHALL add the output port retired, 64 bits.
- retired SHALL be reset to 0.
- It SHALL increment by 1 on each edge where stat is AOK and stays AOK.
- It SHALL wrap modulo 2^64.
- It SHALL freeze once stat leaves AOK.
REQ-026 Without WB_RETIRE_CNT_EN, the retired port and its counter SHALL be absent, with no other change in behaviour.

Structure
REQ-027 A shared package y86_pkg SHALL hold the following constants:
- the icode constants (HALT=0 .. POPQ=11);
- REG_RSP=4;
- REG_NONE=0xF;
- the stat codes AOK, HLT, ADR, INS.
REQ-028 A sub-module regfile SHALL implement the 15x64 array with 2 asynchronous read ports, 2 write ports, the valM-priority rule of REQ-018 and asynchronous clear.
- writeback_rf SHALL contain the src/dst decode logic, the stat state machine and the optional counter.

Verification
REQ-029 Scenario irmovq: icode=3, rB=2, valE=15, edge, then icode=6, rA=2 -> valA=15; stat=AOK.
REQ-030 Scenario cmovXX: icode=2, ifun=1, rA=1, rB=3, valE=7, cnd=0, edge -> register 3 unchanged (0); repeating with cnd=1 -> register 3 = 7.
REQ-031 Scenario popq %rsp: icode=11, rA=4, valE=2047, valM=99, edge -> RSP=99, and srcB=RSP returns 99 as valB.
REQ-032 Scenario stack: pushq with valE=2039 -> RSP=2039; then call with valE=2031 -> RSP=2031; then ret with valE=2039 -> RSP=2039, valA=valB=2039.
REQ-033 Scenario faults:
- dmem_error=1 with icode=5, rA=1, valM=5 -> stat=ADR, register 1 unchanged, halted=1, later writes ignored.
- After a separate reset, instr_valid=0 -> stat=INS.
- After a separate reset, icode=0 -> stat=HLT.
REQ-034 Scenario reset mid-run: after registers 2 and 4 have been written, assert rst_n=0 between edges -> registers 2 and 4 and (if enabled) retired read 0 immediately, and stat=AOK.
